// File: rtl/i2s_fifo_err_status.sv
// I2S FIFO error status: sticky overrun/underrun flags, saturating event counters,
// masked registered interrupt and a one-cycle-latency byte-addressed status read port.
module i2s_fifo_err_chan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             evt,
  input  logic             clr,
  output logic             flag,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // An event in the same cycle as a clear wins: the clear empties the count and the event lands as 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flag <= 1'b0;
      cnt  <= '0;
    end else if (evt) begin
      flag <= 1'b1;
      if (clr)                 cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (clr) begin
      flag <= 1'b0;
      cnt  <= '0;
    end
  end
endmodule

module i2s_fifo_err_status #(
  parameter int          CNT_W     = 8,
  parameter logic [11:0] BASE_ADDR = 12'h020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2si_fifo_ovr_evt,
  input  logic        i2so_fifo_udr_evt,
  input  logic        trig_i2si_fifo_overrun_clr,
  input  logic        trig_i2so_fifo_underrun_clr,
  input  logic [1:0]  irq_en,
  input  logic [11:0] address,
  input  logic        rd,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        i2si_fifo_overrun,
  output logic        i2so_fifo_underrun,
  output logic        irq
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]            evt, clr, flag;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [7:0]                   rd_mux;

  // Channel 0 is the input-FIFO overrun path, channel 1 the output-FIFO underrun path.
  assign evt = {i2so_fifo_udr_evt, i2si_fifo_ovr_evt};
  assign clr = {trig_i2so_fifo_underrun_clr, trig_i2si_fifo_overrun_clr};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    i2s_fifo_err_chan #(.CNT_W(CNT_W)) u_chan (
      .clk  (clk),
      .rst_n(rst_n),
      .evt  (evt[g]),
      .clr  (clr[g]),
      .flag (flag[g]),
      .cnt  (cnt[g])
    );
  end

  assign i2si_fifo_overrun  = flag[0];
  assign i2so_fifo_underrun = flag[1];

  always_comb begin
    rd_mux = 8'h00;
    if      (address == BASE_ADDR)          rd_mux = {6'b0, flag};
    else if (address == BASE_ADDR + 12'd4)  rd_mux = 8'(cnt[0]);
    else if (address == BASE_ADDR + 12'd8)  rd_mux = 8'(cnt[1]);
  end

  // irq and read data are built from pre-edge state, so both lag the flags by a cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq    <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= 8'h00;
    end else begin
      irq    <= |(flag & irq_en);
      rvalid <= rd;
      if (rd) rdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_i2s_fifo_err_status.sv
// Directed bench for i2s_fifo_err_status: reset, flags/irq, saturation, clear collision, read map, masking.
module tb_i2s_fifo_err_status;
  localparam logic [11:0] BASE = 12'h020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ovr, udr, ovr_clr, udr_clr;
  logic [1:0]  irq_en;
  logic [11:0] address;
  logic        rd;
  logic [7:0]  rdata;
  logic        rvalid, overrun, underrun, irq;

  int n_run  = 0;
  int n_fail = 0;

  i2s_fifo_err_status #(.CNT_W(8), .BASE_ADDR(BASE)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .i2si_fifo_ovr_evt          (ovr),
    .i2so_fifo_udr_evt          (udr),
    .trig_i2si_fifo_overrun_clr (ovr_clr),
    .trig_i2so_fifo_underrun_clr(udr_clr),
    .irq_en                     (irq_en),
    .address                    (address),
    .rd                         (rd),
    .rdata                      (rdata),
    .rvalid                     (rvalid),
    .i2si_fifo_overrun          (overrun),
    .i2so_fifo_underrun         (underrun),
    .irq                        (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [7:0] exp);
    address = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    chk({tag, "_vld"}, rvalid, 1);
    chk(tag, rdata, exp);
    tick();
    chk({tag, "_vld0"}, rvalid, 0);
    chk({tag, "_hold"}, rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; ovr = 0; udr = 0; ovr_clr = 0; udr_clr = 0;
    irq_en = 2'b11; address = BASE; rd = 0;
    #1;
    // Reset held 20 cycles with activity toggling
    for (int i = 0; i < 20; i++) begin
      ovr = i[0]; udr = ~i[0]; ovr_clr = i[1]; rd = 1'b1;
      tick();
    end
    chk("rst_ovr", overrun, 0);
    chk("rst_udr", underrun, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1; ovr = 0; udr = 0; ovr_clr = 0; rd = 0;
    tick();
    chk("rel_ovr", overrun, 0);
    chk("rel_udr", underrun, 0);
    chk("rel_irq", irq, 0);
    chk("rel_rvalid", rvalid, 0);

    // Three single-cycle overruns, irq on overrun only
    irq_en = 2'b01;
    ovr = 1; tick();
    chk("ovr_flag", overrun, 1);
    chk("ovr_irq_lag", irq, 0);
    ovr = 0; tick();
    chk("ovr_irq", irq, 1);
    for (int i = 0; i < 2; i++) begin
      ovr = 1; tick(); ovr = 0; tick();
    end
    rd_chk("ovr_cnt3", BASE + 12'd4, 8'h03);
    chk("udr_idle", underrun, 0);

    // Underrun saturation then clear
    irq_en = 2'b10;
    udr = 1;
    for (int i = 0; i < 300; i++) tick();
    udr = 0; tick();
    chk("udr_flag", underrun, 1);
    chk("udr_irq", irq, 1);
    rd_chk("udr_sat", BASE + 12'd8, 8'hFF);
    udr_clr = 1; tick(); udr_clr = 0;
    chk("udr_clr_flag", underrun, 0);
    chk("udr_clr_irq_lag", irq, 1);
    tick();
    chk("udr_clr_irq", irq, 0);
    rd_chk("udr_clr_cnt", BASE + 12'd8, 8'h00);
    chk("ovr_untouched", overrun, 1);

    // Clear/event collision at count 5
    ovr_clr = 1; tick(); ovr_clr = 0;
    chk("ovr_clr_flag", overrun, 0);
    ovr = 1;
    for (int i = 0; i < 5; i++) tick();
    ovr = 0;
    rd_chk("ovr_cnt5", BASE + 12'd4, 8'h05);
    ovr = 1; ovr_clr = 1; tick(); ovr = 0; ovr_clr = 0;
    chk("coll_flag", overrun, 1);
    rd_chk("coll_cnt", BASE + 12'd4, 8'h01);

    // Read sees pre-edge contents when an event lands at the same edge
    ovr = 1; rd = 1; address = BASE + 12'd4; tick(); ovr = 0; rd = 0;
    chk("rd_old_vld", rvalid, 1);
    chk("rd_old", rdata, 8'h01);
    tick();
    rd_chk("rd_new", BASE + 12'd4, 8'h02);

    // Read map with both flags set
    udr = 1; tick(); udr = 0;
    rd_chk("map_base", BASE, 8'h03);
    rd_chk("map_other", 12'h02C, 8'h00);

    // Back-to-back reads
    rd = 1; address = BASE; tick();
    chk("b2b_v0", rvalid, 1);
    chk("b2b_d0", rdata, 8'h03);
    address = BASE + 12'd4; tick(); rd = 0;
    chk("b2b_v1", rvalid, 1);
    chk("b2b_d1", rdata, 8'h02);
    tick();
    chk("b2b_end", rvalid, 0);

    // Masking
    irq_en = 2'b00; tick(); tick();
    chk("mask_irq0", irq, 0);
    irq_en = 2'b10;
    chk("mask_irq_pre", irq, 0);
    tick();
    chk("mask_irq1", irq, 1);

    // Reset coinciding with a read suppresses rvalid
    rd = 1; address = BASE; rst_n = 0; tick(); rd = 0;
    chk("rstrd_vld", rvalid, 0);
    chk("rstrd_ovr", overrun, 0);
    chk("rstrd_udr", underrun, 0);
    chk("rstrd_irq", irq, 0);
    rst_n = 1; tick();
    rd_chk("rstrd_cnt", BASE + 12'd8, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_fifo_err_status.md
I2S_FIFO_ERR_STATUS -- requirements
Module: i2s_fifo_err_status

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of each error event counter; legal range 1..8.
REQ-002 SHALL have parameter BASE_ADDR, default 12'h020: byte address of the first status register.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port i2si_fifo_ovr_evt  input  1  input-FIFO write-while-full; each high cycle counts as one event.
REQ-006 SHALL have port i2so_fifo_udr_evt  input  1  output-FIFO read-while-empty; each high cycle counts as one event.
REQ-007 SHALL have port trig_i2si_fifo_overrun_clr  input  1  one-cycle clear pulse for overrun flag and count.
REQ-008 SHALL have port trig_i2so_fifo_underrun_clr  input  1  one-cycle clear pulse for underrun flag and count.
REQ-009 SHALL have port irq_en  input  2  interrupt mask; bit0 overrun, bit1 underrun.
REQ-010 SHALL have port address  input  12  byte address for status reads.
REQ-011 SHALL have port rd  input  1  read strobe, sampled each cycle.
REQ-012 SHALL have port rdata  output  8  read data.
REQ-013 SHALL have port rvalid  output  1  one-cycle qualifier for rdata.
REQ-014 SHALL have port i2si_fifo_overrun  output  1  sticky overrun flag.
REQ-015 SHALL have port i2so_fifo_underrun  output  1  sticky underrun flag.
REQ-016 SHALL have port irq  output  1  registered interrupt.

Function
REQ-017 Event high at edge N SHALL set the matching flag, visible from edge N; the counter SHALL increment by 1 at the same edge.
REQ-018 Flags SHALL remain set until the matching clear pulse; reads SHALL NOT clear flags or counters.
REQ-019 Counters SHALL saturate at 2^CNT_W-1; further events leave the counter unchanged and the flag set.
REQ-020 Clear pulse alone at edge N SHALL zero the matching flag and counter from edge N.
REQ-021 Clear and event in the same cycle: event SHALL win; the flag ends at 1 and the counter ends at 1.
REQ-022 Overrun and underrun paths SHALL be fully independent; simultaneous activity on both SHALL update both.
REQ-023 irq SHALL be registered as (overrun & irq_en[0]) | (underrun & irq_en[1]), using flag values before the edge, so irq lags a flag by one cycle.
REQ-024 A read with rd high at edge N SHALL drive rdata and rvalid=1 for the cycle after edge N; rvalid SHALL be 0 otherwise.
REQ-025 Read data SHALL be the register contents before edge N, so an update at the same edge is not reflected.
REQ-026 Register map: BASE_ADDR+0 = {6'b0, underrun, overrun}; BASE_ADDR+4 = overrun count; BASE_ADDR+8 = underrun count.
REQ-027 Counts SHALL be zero-extended to 8 bits.
REQ-028 Reads of any other address SHALL return 8'h00 with rvalid=1.
REQ-029 rdata SHALL hold its last value while rvalid=0.
REQ-030 Back-to-back reads (rd high on consecutive cycles) SHALL each produce one rvalid cycle.

Reset
REQ-031 With rst_n low at an edge, all flags, counters, irq, rdata and rvalid SHALL become 0.
REQ-032 During reset, events, clears and rd SHALL be ignored.
REQ-033 Reset mid-read SHALL suppress the pending rvalid.
REQ-034 Normal operation SHALL resume at the first edge with rst_n high.

Verification
REQ-035 Reset: hold rst_n low 20 cycles with events toggling -> all outputs 0; first edge after release with no event -> still 0.
REQ-036 Overrun flag and IRQ: 3 single-cycle overrun events, irq_en=2'b01 -> overrun=1, BASE+4 reads 8'h03, irq=1 one cycle after the flag; underrun=0.
REQ-037 Saturation and clear: 300 consecutive underrun cycles (CNT_W=8) -> BASE+8 reads 8'hFF; clear pulse -> flag 0, count 8'h00, irq falls one cycle later.
REQ-038 Clear/event collision: overrun count at 5, clear and event in the same cycle -> flag 1, count 8'h01.
REQ-039 Read map: read BASE+0 with both flags set -> 8'h03; read 12'h02C -> 8'h00; each read gives exactly one rvalid cycle one cycle after rd.
REQ-040 Masking: both flags set, irq_en=2'b00 -> irq stays 0; irq_en set to 2'b10 -> irq=1 one cycle later.
